// File: rtl/rhythm_lane_arbiter.sv
// rtl/rhythm_lane_arbiter.sv - four-lane press arbiter with beat timestamps (option: RHYTHM_OVERRUN_EN)
module rhythm_lane_arbiter #(
    parameter int STAMP_W = 16
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic [3:0]         i_fPush,
    input  logic               i_Tick,
    input  logic               i_Ready,
    output logic               o_Valid,
    output logic [1:0]         o_Lane,
    output logic [STAMP_W-1:0] o_Stamp,
    output logic [3:0]         o_Pending,
    input  logic               i_OvrClr,
    output logic [3:0]         o_Overrun,
    output logic [7:0]         o_OvrCnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1
    } state_t;

    state_t             r_State;
    state_t             w_Next;
    logic               w_Load;
    logic               w_Done;
    logic               w_Found;
    logic [1:0]         w_Sel;
    logic [1:0]         r_Ptr;
    logic [STAMP_W-1:0] r_Stamp;
    logic [STAMP_W-1:0] r_Slot [4];
    logic [3:0]         r_Pend;
    logic [3:0]         w_Clr;
    logic [3:0]         w_Cap;
    logic [3:0]         w_Ovr;
    logic [3:0]         w_PendNext;

    assign o_Pending = r_Pend;

    // Round-robin pick: lowest offset from r_Ptr among pending lanes wins.
    always_comb begin
        w_Found = 1'b0;
        w_Sel   = r_Ptr;
        for (int i = 3; i >= 0; i--) begin
            if (r_Pend[r_Ptr + 2'(i)]) begin
                w_Found = 1'b1;
                w_Sel   = r_Ptr + 2'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            r_State <= S_IDLE;
        end else begin
            r_State <= w_Next;
        end
    end

    // Next-state: latch an event from idle, release it on handshake.
    always_comb begin
        w_Next = r_State;
        w_Load = 1'b0;
        w_Done = 1'b0;
        case (r_State)
            S_IDLE: begin
                if (w_Found) begin
                    w_Next = S_OFFER;
                    w_Load = 1'b1;
                end
            end
            S_OFFER: begin
                if (i_Ready) begin
                    w_Next = S_IDLE;
                    w_Done = 1'b1;
                end
            end
            default: w_Next = S_IDLE;
        endcase
    end

    // Pending-slot update; a press on the lane being retired refills it instead of overrunning.
    always_comb begin
        w_Clr      = w_Done ? (4'b0001 << o_Lane) : 4'b0000;
        w_Cap      = i_fPush & (~r_Pend | w_Clr);
        w_Ovr      = i_fPush & r_Pend & ~w_Clr;
        w_PendNext = (r_Pend & ~w_Clr) | i_fPush;
    end

    // Stamp counter, slot capture, offered-event registers and pointer.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            r_Stamp <= '0;
            r_Pend  <= 4'b0000;
            r_Ptr   <= 2'd0;
            o_Valid <= 1'b0;
            o_Lane  <= 2'd0;
            o_Stamp <= '0;
            for (int k = 0; k < 4; k++) begin
                r_Slot[k] <= '0;
            end
        end else begin
            r_Stamp <= r_Stamp + STAMP_W'(i_Tick);
            r_Pend  <= w_PendNext;
            o_Valid <= (w_Next == S_OFFER);
            for (int k = 0; k < 4; k++) begin
                if (w_Cap[k]) begin
                    r_Slot[k] <= r_Stamp;
                end
            end
            if (w_Load) begin
                o_Lane  <= w_Sel;
                o_Stamp <= r_Slot[w_Sel];
            end
            if (w_Done) begin
                r_Ptr <= o_Lane + 2'd1;
            end
        end
    end

`ifdef RHYTHM_OVERRUN_EN
    logic [2:0] w_OvrNum;
    logic [8:0] w_CntSum;

    // Count overruns this cycle and add to the running total.
    always_comb begin
        w_OvrNum = {2'b00, w_Ovr[0]} + {2'b00, w_Ovr[1]} + {2'b00, w_Ovr[2]} + {2'b00, w_Ovr[3]};
        w_CntSum = {1'b0, o_OvrCnt} + {6'd0, w_OvrNum};
    end

    // Sticky flags and saturating counter; clear has priority over new overruns.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            o_Overrun <= 4'b0000;
            o_OvrCnt  <= 8'd0;
        end else if (i_OvrClr) begin
            o_Overrun <= 4'b0000;
            o_OvrCnt  <= 8'd0;
        end else begin
            o_Overrun <= o_Overrun | w_Ovr;
            o_OvrCnt  <= w_CntSum[8] ? 8'hFF : w_CntSum[7:0];
        end
    end
`else
    logic unused_ovr;

    assign unused_ovr = ^{i_OvrClr, w_Ovr};
    assign o_Overrun  = 4'b0000;
    assign o_OvrCnt   = 8'd0;
`endif

endmodule
